sl_transmitter: RTL

Clocked transmitter for the two-wire SL serial link (sl0/sl1, both idle high). It accepts a 32-bit word and a bit-count over a valid/ready handshake. It serialises the word LSB-first as negative pulses, appends an odd-parity pulse and terminates with a stop condition (both lines low). It is the transmit-side counterpart of the SL receiver and feeds SL lines toward an external or loop-back receiver.

---
 rtl/sl_pkg.sv | 9 +
 rtl/sl_transmitter_if.sv | 12 +
 rtl/sl_phase_timer.sv | 20 ++
 rtl/sl_transmitter.sv | 98 +++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// sl_pkg: SL link types, word-length limits and length decode, shared by the transmitter and receiver
package sl_pkg;
  typedef enum logic [2:0] {IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH} sl_tx_state_t;
  localparam int SL_MIN_BITS = 8;
  localparam int SL_MAX_BITS = 32;
  function automatic logic [5:0] sl_word_len(input logic [4:0] bc);
    return (bc > 5'd7) ? {1'b0, bc} + 6'd1 : 6'(SL_MIN_BITS);
  endfunction
endpackage

// File: rtl/sl_transmitter_if.sv
// sl_transmitter_if: word handshake between a host (master) and sl_transmitter (slave)
//   tx_valid/tx_ready  valid/ready handshake
//   tx_data            payload, bit0 sent first
//   tx_bit_count       length code, decoded by sl_word_len
interface sl_transmitter_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic [4:0]  tx_bit_count;
  modport master (output tx_valid, tx_data, tx_bit_count, input tx_ready);
  modport slave (input tx_valid, tx_data, tx_bit_count, output tx_ready);
endinterface

// File: rtl/sl_phase_timer.sv
// sl_phase_timer: loadable down-counter with zero flag that times each low/high line phase
//   clk, reset_n  clock, async active-low reset
//   i_load/i_val  load the count (phase length - 1)
//   o_zero        count has reached zero (last cycle of the phase)
module sl_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (!o_zero) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/sl_transmitter.sv
// sl_transmitter: serialises a word LSB-first as SL low pulses, then odd parity and a stop (both lines low)
//   clk, reset_n        clock, async active-low reset
//   bus (slave)         tx_valid/tx_ready/tx_data/tx_bit_count handshake
//   inj_parity_err      only with SL_TX_PARITY_INJECT_EN: invert the parity of the accepted word
//   sl0, sl1            idle-high SL lines, driven straight from flops
//   busy, done          word in progress / last cycle of the word
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int LOW_CYC  = 4,
  parameter int HIGH_CYC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  sl_transmitter_if.slave   bus,
`ifdef SL_TX_PARITY_INJECT_EN
  input  logic              inj_parity_err,
`endif
  output logic              sl0,
  output logic              sl1,
  output logic              busy,
  output logic              done
);
  localparam int TW = $clog2((LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC) + 1;
  sl_tx_state_t r_state;
  logic [5:0]   r_idx, r_n;
  logic [31:0]  r_data;
  logic         r_par, r_sl0, r_sl1;
  logic         w_zero, w_ready, w_accept, w_load, w_inj, w_par, w_nbit, w_more;
  logic [5:0]   w_n, w_nidx;
  logic [31:0]  w_mask;
  logic [TW-1:0] w_val;
`ifdef SL_TX_PARITY_INJECT_EN
  assign w_inj = inj_parity_err;
`else
  assign w_inj = 1'b0;
`endif
  assign w_n      = sl_word_len(bus.tx_bit_count);
  assign w_mask   = 32'hFFFF_FFFF >> (6'(SL_MAX_BITS) - w_n);
  assign w_par    = ~^(bus.tx_data & w_mask) ^ w_inj;
  // the last STOP_HIGH cycle doubles as an accept slot so back-to-back words keep a HIGH_CYC gap
  assign w_ready  = r_state == IDLE || (r_state == STOP_HIGH && w_zero);
  assign w_accept = bus.tx_valid && w_ready;
  assign w_nidx   = r_idx + 6'd1;
  assign w_more   = r_idx < r_n;
  assign w_nbit   = (w_nidx == r_n) ? r_par : r_data[w_nidx[4:0]];
  assign w_load   = w_accept || (w_zero && (r_state == BIT_LOW || r_state == BIT_HIGH || r_state == STOP_LOW));
  assign w_val    = (w_accept || r_state == BIT_HIGH) ? TW'(LOW_CYC - 1) : TW'(HIGH_CYC - 1);
  assign bus.tx_ready = w_ready;
  assign busy     = !w_ready;
  assign done     = r_state == STOP_HIGH && w_zero;
  assign sl0      = r_sl0;
  assign sl1      = r_sl1;
  sl_phase_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .i_load (w_load),
    .i_val  (w_val),
    .o_zero (w_zero)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_n     <= '0;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_sl0   <= 1'b1;
      r_sl1   <= 1'b1;
    end else if (w_accept) begin
      r_state <= BIT_LOW;
      r_idx   <= '0;
      r_n     <= w_n;
      r_data  <= bus.tx_data;
      r_par   <= w_par;
      r_sl0   <= bus.tx_data[0];
      r_sl1   <= !bus.tx_data[0];
    end else if (w_zero)
      case (r_state)
        BIT_LOW: begin
          r_state <= BIT_HIGH;
          r_sl0   <= 1'b1;
          r_sl1   <= 1'b1;
        end
        BIT_HIGH: begin
          r_idx   <= w_nidx;
          r_state <= w_more ? BIT_LOW : STOP_LOW;
          r_sl0   <= w_more && w_nbit;
          r_sl1   <= w_more && !w_nbit;
        end
        STOP_LOW: begin
          r_state <= STOP_HIGH;
          r_sl0   <= 1'b1;
          r_sl1   <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
endmodule
